// File: rtl/fu_writeback_unit_if.sv
// Handshake bundle between a functional unit, the writeback buffer and the GPR write port.
// master drives FU results, GPR-port ready and the forwarding query; slave is the writeback unit.
interface fu_writeback_unit_if #(
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5,
  parameter int PC_SZ   = 32,
  parameter int CNT_SZ  = 32
);
  logic               valid_in;
  logic               rdy_out;
  logic [GPR_ASZ-1:0] rd_in;
  logic               wr_en_in;
  logic [RSZ-1:0]     result_in;
  logic [PC_SZ-1:0]   pc_in;
  logic               gpr_wr_valid_out;
  logic               gpr_wr_rdy_in;
  logic [GPR_ASZ-1:0] gpr_wr_addr_out;
  logic [RSZ-1:0]     gpr_wr_data_out;
  logic [GPR_ASZ-1:0] fwd_rs_in;
  logic               fwd_hit_out;
  logic [RSZ-1:0]     fwd_data_out;
  logic [CNT_SZ-1:0]  retire_cnt_out;
  logic [PC_SZ-1:0]   last_pc_out;
  logic               empty_out;

  modport master (
    output valid_in, rd_in, wr_en_in, result_in, pc_in, gpr_wr_rdy_in, fwd_rs_in,
    input  rdy_out, gpr_wr_valid_out, gpr_wr_addr_out, gpr_wr_data_out,
           fwd_hit_out, fwd_data_out, retire_cnt_out, last_pc_out, empty_out
  );

  modport slave (
    input  valid_in, rd_in, wr_en_in, result_in, pc_in, gpr_wr_rdy_in, fwd_rs_in,
    output rdy_out, gpr_wr_valid_out, gpr_wr_addr_out, gpr_wr_data_out,
           fwd_hit_out, fwd_data_out, retire_cnt_out, last_pc_out, empty_out
  );
endinterface

// File: rtl/fu_writeback_unit.sv
// In-order writeback buffer: FU results enter a DEPTH-entry FIFO and retire to one GPR write port.
// One-cycle accept-to-write latency; rdy_out falls only on a registered full count, GPR stalls hold the head.
module fu_writeback_unit #(
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5,
  parameter int PC_SZ   = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_SZ  = 32
) (
  input logic                clk_in,
  input logic                reset_in,
  fu_writeback_unit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [GPR_ASZ-1:0] r_rd   [DEPTH];
  logic [RSZ-1:0]     r_data [DEPTH];
  logic [PC_SZ-1:0]   r_pc   [DEPTH];
  logic [DEPTH-1:0]   r_wen;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_rdy;
  logic [CNT_SZ-1:0]  r_retire_cnt;
  logic [PC_SZ-1:0]   r_last_pc;

  logic               w_head_vld;
  logic               w_head_real;
  logic               w_push;
  logic               w_pop;
  logic [CW-1:0]      w_count_nxt;
  logic [PW-1:0]      w_idx [DEPTH];
  logic               w_fwd_hit;
  logic [RSZ-1:0]     w_fwd_data;

  assign w_head_vld  = (r_count != '0);
  assign w_head_real = r_wen[r_rd_ptr] && (r_rd[r_rd_ptr] != '0);
  assign w_push      = bus.valid_in && r_rdy;
  // Non-writing entries (wr_en=0 or x0) retire without waiting on the GPR port.
  assign w_pop       = w_head_vld && (!w_head_real || bus.gpr_wr_rdy_in);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
      r_wen        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_rdy        <= 1'b0;
      r_retire_cnt <= '0;
      r_last_pc    <= '0;
    end else begin
      if (w_push) begin
        r_rd[r_wr_ptr]   <= bus.rd_in;
        r_wen[r_wr_ptr]  <= bus.wr_en_in;
        r_data[r_wr_ptr] <= bus.result_in;
        r_pc[r_wr_ptr]   <= bus.pc_in;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + 1'b1;
        r_retire_cnt <= r_retire_cnt + 1'b1;
        r_last_pc    <= r_pc[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      // Ready is kept as a flop of the next count so it never sees the same-cycle pop.
      r_rdy   <= (w_count_nxt != FULL);
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_idx[k] = r_rd_ptr + PW'(k);
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest one.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) && r_wen[w_idx[k]] && (r_rd[w_idx[k]] != '0) &&
          (r_rd[w_idx[k]] == bus.fwd_rs_in)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[w_idx[k]];
      end
    end
  end

  assign bus.rdy_out          = r_rdy;
  assign bus.gpr_wr_valid_out = w_head_vld && w_head_real;
  assign bus.gpr_wr_addr_out  = r_rd[r_rd_ptr];
  assign bus.gpr_wr_data_out  = r_data[r_rd_ptr];
  assign bus.fwd_hit_out      = w_fwd_hit;
  assign bus.fwd_data_out     = w_fwd_data;
  assign bus.retire_cnt_out   = r_retire_cnt;
  assign bus.last_pc_out      = r_last_pc;
  assign bus.empty_out        = (r_count == '0);
endmodule
